// File: rtl/key_event_tx.sv
// key_event_tx
//   Producer side of the key-event interface into the predictor top level.
//   The two active-low push-buttons are synchronised and debounced. Each
//   debounced press becomes a signed symbol: key0 gives +1 and key1 gives -1.
//   The symbol is offered on a valid/ready handshake. A two-entry ordered
//   buffer holds the output register plus one pending slot. Presses that
//   arrive while the consumer is busy are queued. If both entries are full,
//   the press is dropped and flagged.
//
// Ports
//   CLOCK_50  in   system clock
//   rst       in   asynchronous active-high reset
//   key0      in   raw button, active-low, press sends +1
//   key1      in   raw button, active-low, press sends -1
//   ready     in   consumer can take a symbol this cycle
//   valid     out  xin holds a symbol awaiting transfer
//   xin       out  signed symbol (2'b01 = +1, 2'b11 = -1)
//   pending   out  pending slot occupied
//   dropped   out  one-cycle pulse, a press was discarded (buffer full)
module key_event_tx #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              key0,
    input  logic              key1,
    input  logic              ready,
    output logic              valid,
    output logic signed [1:0] xin,
    output logic              pending,
    output logic              dropped
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 belongs to key0 and bit 1 belongs to key1 throughout.
    logic [1:0]            sync_p0;
    logic [1:0]            ks;
    logic [1:0]            stable;
    logic [1:0]            stable_d;
    logic [1:0]            armed;
    logic [1:0]            press;
    logic [1:0][CNT_W-1:0] cnt;

    logic signed [1:0] pend_sym;
    logic              xfer;
    logic              nxt_valid;
    logic              nxt_pending;
    logic              nxt_drop;
    logic signed [1:0] nxt_xin;
    logic signed [1:0] nxt_pend_sym;

    function automatic logic signed [1:0] key_sym(input int idx);
        return (idx == 0) ? 2'sb01 : 2'sb11;
    endfunction

    // Synchroniser, debounce and press strobe.
    // After reset a key starts disarmed. It must first be seen released for
    // DEBOUNCE_CYCLES consecutive cycles. Only then does normal debouncing
    // begin. This stops a button held through reset from producing a press.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync_p0  <= 2'b11;
            ks       <= 2'b11;
            stable   <= 2'b11;
            stable_d <= 2'b11;
            armed    <= 2'b00;
            press    <= 2'b00;
            cnt      <= '0;
        end else begin
            sync_p0  <= {key1, key0};
            ks       <= sync_p0;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            for (int i = 0; i < 2; i++) begin
                if (!armed[i]) begin
                    if (!ks[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        armed[i] <= 1'b1;
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (ks[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ks[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Buffer next-state logic.
    // A transfer first advances the pending symbol into the output register.
    // New presses then fill free entries in order, key0 before key1.
    assign xfer = valid & ready;

    always_comb begin
        nxt_valid    = valid;
        nxt_xin      = xin;
        nxt_pending  = pending;
        nxt_pend_sym = pend_sym;
        nxt_drop     = 1'b0;
        if (xfer) begin
            nxt_valid   = pending;
            nxt_pending = 1'b0;
            if (pending) nxt_xin = pend_sym;
        end
        for (int i = 0; i < 2; i++) begin
            if (press[i]) begin
                if (!nxt_valid) begin
                    nxt_valid = 1'b1;
                    nxt_xin   = key_sym(i);
                end else if (!nxt_pending) begin
                    nxt_pending  = 1'b1;
                    nxt_pend_sym = key_sym(i);
                end else begin
                    nxt_drop = 1'b1;
                end
            end
        end
    end

    // Buffer registers, which drive the outputs directly.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            xin      <= 2'sb01;
            pending  <= 1'b0;
            pend_sym <= 2'sb01;
            dropped  <= 1'b0;
        end else begin
            valid    <= nxt_valid;
            xin      <= nxt_xin;
            pending  <= nxt_pending;
            pend_sym <= nxt_pend_sym;
            dropped  <= nxt_drop;
        end
    end

endmodule

// File: tb/tb_key_event_tx.sv
module tb_key_event_tx;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic       key0     = 1'b1;
    logic       key1     = 1'b1;
    logic       ready    = 1'b0;
    logic       valid;
    logic [1:0] xin;
    logic       pending;
    logic       dropped;

    int tests = 0;
    int fails = 0;

    key_event_tx #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .key0     (key0),
        .key1     (key1),
        .ready    (ready),
        .valid    (valid),
        .xin      (xin),
        .pending  (pending),
        .dropped  (dropped)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold a key low long enough to register, then release it long enough
    // for the release to settle.
    task automatic tap(input int k);
        if (k == 0) key0 = 1'b0; else key1 = 1'b0;
        cyc(8);
        if (k == 0) key0 = 1'b1; else key1 = 1'b1;
        cyc(8);
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("rst_valid",   {7'd0, valid},   8'd0);
        chk("rst_xin",     {6'd0, xin},     8'h01);
        chk("rst_pending", {7'd0, pending}, 8'd0);
        chk("rst_dropped", {7'd0, dropped}, 8'd0);
        rst = 1'b0;
        cyc(10);

        // Latency: key0 low before edge E, valid expected at edge E+7
        key0 = 1'b0;
        cyc(7);
        chk("lat_early_valid", {7'd0, valid}, 8'd0);
        cyc(1);
        chk("lat_valid",   {7'd0, valid},   8'd1);
        chk("lat_xin",     {6'd0, xin},     8'h01);
        chk("lat_pending", {7'd0, pending}, 8'd0);
        cyc(5);
        chk("hold_valid", {7'd0, valid}, 8'd1);
        chk("hold_xin",   {6'd0, xin},   8'h01);
        key0 = 1'b1;
        cyc(10);
        chk("release_no_event", {7'd0, pending}, 8'd0);
        pulse_ready();
        chk("xfer_empty_valid", {7'd0, valid}, 8'd0);

        // Glitch shorter than the debounce window
        key1 = 1'b0;
        cyc(3);
        key1 = 1'b1;
        cyc(12);
        chk("glitch_valid",   {7'd0, valid},   8'd0);
        chk("glitch_dropped", {7'd0, dropped}, 8'd0);
        chk("glitch_cnt",     8'(dut.cnt[1]),  8'd0);

        // Three presses, the third one overflows
        tap(0);
        chk("q1_valid",   {7'd0, valid},   8'd1);
        chk("q1_pending", {7'd0, pending}, 8'd0);
        tap(1);
        chk("q2_xin",     {6'd0, xin},     8'h01);
        chk("q2_pending", {7'd0, pending}, 8'd1);
        key0 = 1'b0;
        cyc(7);
        chk("q3_drop_before", {7'd0, dropped}, 8'd0);
        cyc(1);
        chk("q3_drop_pulse", {7'd0, dropped}, 8'd1);
        cyc(1);
        chk("q3_drop_after", {7'd0, dropped}, 8'd0);
        key0 = 1'b1;
        cyc(10);
        chk("q3_xin",     {6'd0, xin},     8'h01);
        chk("q3_pending", {7'd0, pending}, 8'd1);
        ready = 1'b1;
        cyc(1);
        chk("d1_valid",   {7'd0, valid},   8'd1);
        chk("d1_xin",     {6'd0, xin},     8'h03);
        chk("d1_pending", {7'd0, pending}, 8'd0);
        cyc(1);
        ready = 1'b0;
        chk("d2_valid", {7'd0, valid}, 8'd0);

        // Both keys pressed in the same cycle
        key0 = 1'b0;
        key1 = 1'b0;
        cyc(8);
        chk("both_valid",   {7'd0, valid},   8'd1);
        chk("both_xin",     {6'd0, xin},     8'h01);
        chk("both_pending", {7'd0, pending}, 8'd1);
        chk("both_dropped", {7'd0, dropped}, 8'd0);
        key0 = 1'b1;
        key1 = 1'b1;
        cyc(10);
        pulse_ready();
        chk("both_x1_xin",     {6'd0, xin},     8'h03);
        chk("both_x1_pending", {7'd0, pending}, 8'd0);
        chk("both_x1_valid",   {7'd0, valid},   8'd1);
        pulse_ready();
        chk("both_x2_valid", {7'd0, valid}, 8'd0);

        // Full buffer, transfer on the same edge as a new key1 event
        key0 = 1'b0;
        key1 = 1'b0;
        cyc(8);
        key0 = 1'b1;
        key1 = 1'b1;
        cyc(10);
        chk("full_pending", {7'd0, pending}, 8'd1);
        key1 = 1'b0;
        cyc(7);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("sim_valid",   {7'd0, valid},   8'd1);
        chk("sim_xin",     {6'd0, xin},     8'h03);
        chk("sim_pending", {7'd0, pending}, 8'd1);
        chk("sim_dropped", {7'd0, dropped}, 8'd0);
        key1 = 1'b1;
        cyc(10);
        pulse_ready();
        chk("sim_x2_xin",     {6'd0, xin},     8'h03);
        chk("sim_x2_pending", {7'd0, pending}, 8'd0);
        pulse_ready();
        chk("sim_x3_valid", {7'd0, valid}, 8'd0);

        // Reset mid-operation with key0 held low
        key0 = 1'b0;
        key1 = 1'b0;
        cyc(8);
        key1 = 1'b1;
        cyc(10);
        chk("pre_rst_pending", {7'd0, pending}, 8'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",   {7'd0, valid},   8'd0);
        chk("mid_rst_pending", {7'd0, pending}, 8'd0);
        chk("mid_rst_dropped", {7'd0, dropped}, 8'd0);
        cyc(2);
        rst = 1'b0;
        cyc(20);
        chk("held_no_event", {7'd0, valid}, 8'd0);
        key0 = 1'b1;
        cyc(10);
        chk("rearm_no_event", {7'd0, valid}, 8'd0);
        key0 = 1'b0;
        cyc(8);
        chk("rearm_valid", {7'd0, valid}, 8'd1);
        chk("rearm_xin",   {6'd0, xin},   8'h01);
        key0 = 1'b1;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
